// File: rtl/ct_biu_outstd_tracker_if.sv
// Bus-side signal bundle for ct_biu_outstd_tracker.
// master: the BIU/pad side that produces handshakes and consumes the indications.
// slave : the tracker itself.
interface ct_biu_outstd_tracker_if;
  logic       rd_req_vld;
  logic       biu_pad_arvalid;
  logic       pad_biu_arready;
  logic       pad_biu_rvalid;
  logic       biu_pad_rready;
  logic       pad_biu_rlast;
  logic       wr_req_vld;
  logic       biu_pad_awvalid;
  logic       pad_biu_awready;
  logic       biu_pad_wvalid;
  logic       pad_biu_bvalid;
  logic       biu_pad_bready;
  logic       cp0_biu_lpmd_req;
  logic       read_busy;
  logic       write_busy;
  logic       read_ar_clk_en;
  logic       read_r_clk_en;
  logic       write_b_clk_en;
  logic       biu_lpmd_block;
  logic       biu_cp0_lpmd_ack;
  logic       rd_cnt_full;
  logic       wr_cnt_full;
  logic [1:0] biu_outstd_err;

  modport master (
    output rd_req_vld, biu_pad_arvalid, pad_biu_arready,
    output pad_biu_rvalid, biu_pad_rready, pad_biu_rlast,
    output wr_req_vld, biu_pad_awvalid, pad_biu_awready, biu_pad_wvalid,
    output pad_biu_bvalid, biu_pad_bready, cp0_biu_lpmd_req,
    input  read_busy, write_busy, read_ar_clk_en, read_r_clk_en, write_b_clk_en,
    input  biu_lpmd_block, biu_cp0_lpmd_ack, rd_cnt_full, wr_cnt_full, biu_outstd_err
  );

  modport slave (
    input  rd_req_vld, biu_pad_arvalid, pad_biu_arready,
    input  pad_biu_rvalid, biu_pad_rready, pad_biu_rlast,
    input  wr_req_vld, biu_pad_awvalid, pad_biu_awready, biu_pad_wvalid,
    input  pad_biu_bvalid, biu_pad_bready, cp0_biu_lpmd_req,
    output read_busy, write_busy, read_ar_clk_en, read_r_clk_en, write_b_clk_en,
    output biu_lpmd_block, biu_cp0_lpmd_ack, rd_cnt_full, wr_cnt_full, biu_outstd_err
  );
endinterface

// File: rtl/ct_biu_outstd_tracker.sv
// Outstanding AXI read/write tracker with low-power request/ack handshake.
// Counts accepted AR/AW against returned R-last/B, derives busy and gated-clock
// enables, and acknowledges CP0 low-power requests once the bus stays quiet for
// QUIET_DLY consecutive cycles. Runs on the free-running core clock.
// Optional feature: define CT_BIU_OUTSTD_ERR_EN to build sticky overflow/underflow
// flags on biu_outstd_err; otherwise the flags are tied to zero.
module ct_biu_outstd_tracker #(
  parameter int RD_MAX    = 16,
  parameter int WR_MAX    = 16,
  parameter int CNT_W     = 5,
  parameter int QUIET_DLY = 2
) (
  input  logic                     forever_coreclk,
  input  logic                     cpurst_b,
  ct_biu_outstd_tracker_if.slave   bus
);

  typedef enum logic [1:0] {LP_IDLE, LP_QUIET, LP_ACK} lp_state_e;

  localparam logic [CNT_W-1:0] RD_MAX_C    = CNT_W'(RD_MAX);
  localparam logic [CNT_W-1:0] WR_MAX_C    = CNT_W'(WR_MAX);
  localparam logic [3:0]       QUIET_DLY_C = 4'(QUIET_DLY);

  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  lp_state_e        state_q, state_d;
  logic [3:0]       quiet_cnt_q, quiet_cnt_d;
  logic [3:0]       quiet_inc;

  logic rd_inc, rd_dec, wr_inc, wr_dec;
  logic rd_full, wr_full, rd_empty, wr_empty;
  logic rd_busy, wr_busy;

  assign rd_inc   = bus.biu_pad_arvalid & bus.pad_biu_arready;
  assign rd_dec   = bus.pad_biu_rvalid & bus.biu_pad_rready & bus.pad_biu_rlast;
  assign wr_inc   = bus.biu_pad_awvalid & bus.pad_biu_awready;
  assign wr_dec   = bus.pad_biu_bvalid & bus.biu_pad_bready;
  assign rd_full  = (rd_cnt_q == RD_MAX_C);
  assign wr_full  = (wr_cnt_q == WR_MAX_C);
  assign rd_empty = (rd_cnt_q == '0);
  assign wr_empty = (wr_cnt_q == '0);

  assign rd_busy = ~rd_empty | bus.rd_req_vld | bus.biu_pad_arvalid;
  assign wr_busy = ~wr_empty | bus.wr_req_vld | bus.biu_pad_awvalid | bus.biu_pad_wvalid;

  assign bus.read_busy        = rd_busy;
  assign bus.write_busy       = wr_busy;
  assign bus.read_ar_clk_en   = bus.rd_req_vld | bus.biu_pad_arvalid;
  assign bus.read_r_clk_en    = ~rd_empty | bus.pad_biu_rvalid;
  assign bus.write_b_clk_en   = ~wr_empty | bus.pad_biu_bvalid;
  assign bus.rd_cnt_full      = rd_full;
  assign bus.wr_cnt_full      = wr_full;
  assign bus.biu_lpmd_block   = (state_q != LP_IDLE);
  assign bus.biu_cp0_lpmd_ack = (state_q == LP_ACK);

  // Saturating up/down counters; simultaneous inc and dec cancel out.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (rd_inc && !rd_dec && !rd_full)       rd_cnt_d = rd_cnt_q + CNT_W'(1);
    else if (rd_dec && !rd_inc && !rd_empty) rd_cnt_d = rd_cnt_q - CNT_W'(1);
    if (wr_inc && !wr_dec && !wr_full)       wr_cnt_d = wr_cnt_q + CNT_W'(1);
    else if (wr_dec && !wr_inc && !wr_empty) wr_cnt_d = wr_cnt_q - CNT_W'(1);
  end

  // Low-power FSM: block issue, wait for QUIET_DLY idle cycles, then ack.
  always_comb begin
    state_d     = state_q;
    quiet_cnt_d = quiet_cnt_q;
    quiet_inc   = quiet_cnt_q + 4'd1;
    case (state_q)
      LP_IDLE: begin
        if (bus.cp0_biu_lpmd_req) begin
          state_d     = LP_QUIET;
          quiet_cnt_d = '0;
        end
      end
      LP_QUIET: begin
        if (!bus.cp0_biu_lpmd_req) begin
          state_d     = LP_IDLE;
          quiet_cnt_d = '0;
        end else if (rd_busy || wr_busy) begin
          quiet_cnt_d = '0;
        end else begin
          quiet_cnt_d = quiet_inc;
          if (quiet_inc == QUIET_DLY_C) state_d = LP_ACK;
        end
      end
      LP_ACK: begin
        // Busy here means the bus misbehaved; ack is held until req drops.
        if (!bus.cp0_biu_lpmd_req) state_d = LP_IDLE;
      end
      default: state_d = LP_IDLE;
    endcase
  end

  // State registers for counters and the low-power FSM.
  always_ff @(posedge forever_coreclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      state_q     <= LP_IDLE;
      quiet_cnt_q <= '0;
    end else begin
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      state_q     <= state_d;
      quiet_cnt_q <= quiet_cnt_d;
    end
  end

`ifdef CT_BIU_OUTSTD_ERR_EN
  logic [1:0] err_q, err_d;

  // Sticky error flags: [0] read over/underflow, [1] write over/underflow.
  always_comb begin
    err_d = err_q;
    if ((rd_inc && !rd_dec && rd_full) || (rd_dec && !rd_inc && rd_empty)) err_d[0] = 1'b1;
    if ((wr_inc && !wr_dec && wr_full) || (wr_dec && !wr_inc && wr_empty)) err_d[1] = 1'b1;
  end

  // Error flag register, cleared only by reset.
  always_ff @(posedge forever_coreclk or negedge cpurst_b) begin
    if (!cpurst_b) err_q <= '0;
    else           err_q <= err_d;
  end

  assign bus.biu_outstd_err = err_q;
`else
  assign bus.biu_outstd_err = 2'b00;
`endif

endmodule

// File: tb/tb_ct_biu_outstd_tracker.sv
// Self-checking bench for ct_biu_outstd_tracker: directed scenarios followed by
// randomized traffic, every cycle compared against a behavioural model.
module tb_ct_biu_outstd_tracker;
  localparam int RD_MAX    = 16;
  localparam int WR_MAX    = 16;
  localparam int QUIET_DLY = 2;
`ifdef CT_BIU_OUTSTD_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic clk;
  logic rst_b;
  int   n_total;
  int   n_bad;

  ct_biu_outstd_tracker_if bus_if ();

  ct_biu_outstd_tracker #(
    .RD_MAX(RD_MAX), .WR_MAX(WR_MAX), .CNT_W(5), .QUIET_DLY(QUIET_DLY)
  ) dut (
    .forever_coreclk (clk),
    .cpurst_b        (rst_b),
    .bus             (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer outstanding counts plus low-power progress.
  int rd_m, wr_m;
  bit [1:0] err_m;
  bit blocked_m, acked_m;
  int idle_run_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    rd_m = 0; wr_m = 0; err_m = '0;
    blocked_m = 0; acked_m = 0; idle_run_m = 0;
  endtask

  function automatic bit m_rbusy();
    return (rd_m != 0) || bus_if.rd_req_vld || bus_if.biu_pad_arvalid;
  endfunction

  function automatic bit m_wbusy();
    return (wr_m != 0) || bus_if.wr_req_vld || bus_if.biu_pad_awvalid || bus_if.biu_pad_wvalid;
  endfunction

  task automatic check_all();
    chk("read_busy",  bus_if.read_busy,  m_rbusy());
    chk("write_busy", bus_if.write_busy, m_wbusy());
    chk("ar_clk_en",  bus_if.read_ar_clk_en, bus_if.rd_req_vld | bus_if.biu_pad_arvalid);
    chk("r_clk_en",   bus_if.read_r_clk_en,  (rd_m != 0) | bus_if.pad_biu_rvalid);
    chk("b_clk_en",   bus_if.write_b_clk_en, (wr_m != 0) | bus_if.pad_biu_bvalid);
    chk("rd_full",    bus_if.rd_cnt_full, rd_m == RD_MAX);
    chk("wr_full",    bus_if.wr_cnt_full, wr_m == WR_MAX);
    chk("block",      bus_if.biu_lpmd_block, blocked_m);
    chk("ack",        bus_if.biu_cp0_lpmd_ack, acked_m);
    chk("err",        bus_if.biu_outstd_err, err_m);
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    bit ri, rd, wi, wd, busy, req;
    ri = bus_if.biu_pad_arvalid & bus_if.pad_biu_arready;
    rd = bus_if.pad_biu_rvalid & bus_if.biu_pad_rready & bus_if.pad_biu_rlast;
    wi = bus_if.biu_pad_awvalid & bus_if.pad_biu_awready;
    wd = bus_if.pad_biu_bvalid & bus_if.biu_pad_bready;
    busy = m_rbusy() | m_wbusy();
    req = bus_if.cp0_biu_lpmd_req;
    if (ri && !rd) begin
      if (rd_m == RD_MAX) err_m[0] = ERR_ON; else rd_m++;
    end else if (rd && !ri) begin
      if (rd_m == 0) err_m[0] = ERR_ON; else rd_m--;
    end
    if (wi && !wd) begin
      if (wr_m == WR_MAX) err_m[1] = ERR_ON; else wr_m++;
    end else if (wd && !wi) begin
      if (wr_m == 0) err_m[1] = ERR_ON; else wr_m--;
    end
    if (!req) begin
      blocked_m = 0; acked_m = 0; idle_run_m = 0;
    end else if (!blocked_m) begin
      blocked_m = 1; idle_run_m = 0;
    end else if (!acked_m) begin
      idle_run_m = busy ? 0 : idle_run_m + 1;
      if (idle_run_m >= QUIET_DLY) acked_m = 1;
    end
  endtask

  // One clock: check at the falling edge, then step model across the rising edge.
  task automatic cycle();
    @(negedge clk);
    check_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit rdq, arv, arr, rv, rr, rl, wrq, awv, awr, wv, bv, br, lp);
    bus_if.rd_req_vld = rdq; bus_if.biu_pad_arvalid = arv; bus_if.pad_biu_arready = arr;
    bus_if.pad_biu_rvalid = rv; bus_if.biu_pad_rready = rr; bus_if.pad_biu_rlast = rl;
    bus_if.wr_req_vld = wrq; bus_if.biu_pad_awvalid = awv; bus_if.pad_biu_awready = awr;
    bus_if.biu_pad_wvalid = wv; bus_if.pad_biu_bvalid = bv; bus_if.biu_pad_bready = br;
    bus_if.cp0_biu_lpmd_req = lp;
  endtask

  task automatic idle(input bit lp);
    drv(0,0,0, 0,0,0, 0,0,0,0, 0,0, lp);
  endtask

  initial begin
    int n;
    int mode;
    n_total = 0;
    n_bad   = 0;
    model_reset();
    idle(0);
    rst_b = 1'b0;
    #12;
    chk("rst_block", bus_if.biu_lpmd_block, 0);
    chk("rst_ack",   bus_if.biu_cp0_lpmd_ack, 0);
    chk("rst_rbusy", bus_if.read_busy, 0);
    chk("rst_wfull", bus_if.wr_cnt_full, 0);
    chk("rst_err",   bus_if.biu_outstd_err, 0);
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk);
    #1;

    // Three reads out, three R-last back.
    repeat (3) begin drv(0,1,1, 0,0,0, 0,0,0,0, 0,0, 0); cycle(); end
    repeat (3) begin drv(0,0,0, 1,1,1, 0,0,0,0, 0,0, 0); cycle(); end
    idle(0); cycle();
    chk("rd_drained", bus_if.read_busy, 0);

    // Simultaneous accept and last at count 4.
    repeat (4) begin drv(0,1,1, 0,0,0, 0,0,0,0, 0,0, 0); cycle(); end
    drv(0,1,1, 1,1,1, 0,0,0,0, 0,0, 0); cycle();
    chk("simul_err", bus_if.biu_outstd_err, 0);
    repeat (4) begin drv(0,0,0, 1,1,1, 0,0,0,0, 0,0, 0); cycle(); end

    // Fill writes, overflow, drain, underflow.
    repeat (16) begin drv(0,0,0, 0,0,0, 0,1,1,0, 0,0, 0); cycle(); end
    idle(0); #1;
    chk("wr_full16", bus_if.wr_cnt_full, 1);
    drv(0,0,0, 0,0,0, 0,1,1,0, 0,0, 0); cycle();
    idle(0); #1;
    chk("wr_ovf", {31'd0, bus_if.biu_outstd_err[1]}, {31'd0, ERR_ON});
    chk("wr_hold", bus_if.wr_cnt_full, 1);
    repeat (16) begin drv(0,0,0, 0,0,0, 0,0,0,0, 1,1, 0); cycle(); end
    drv(0,0,0, 0,0,0, 0,0,0,0, 1,1, 0); cycle();
    idle(0); #1;
    chk("wr_udf_cnt", bus_if.write_b_clk_en, 0);

    // Low-power request on an idle bus.
    n = 0;
    idle(1);
    cycle(); n++;
    chk("blk_1edge", bus_if.biu_lpmd_block, 1);
    while (!bus_if.biu_cp0_lpmd_ack && n < 20) begin cycle(); n++; end
    chk("ack_lat", n, QUIET_DLY + 1);
    idle(0); cycle();
    chk("ack_drop", bus_if.biu_cp0_lpmd_ack, 0);
    chk("blk_drop", bus_if.biu_lpmd_block, 0);

    // Request while two reads are outstanding.
    repeat (2) begin drv(0,1,1, 0,0,0, 0,0,0,0, 0,0, 0); cycle(); end
    idle(1); repeat (4) cycle();
    chk("ack_wait", bus_if.biu_cp0_lpmd_ack, 0);
    repeat (2) begin drv(0,0,0, 1,1,1, 0,0,0,0, 0,0, 1); cycle(); end
    idle(1);
    n = 0;
    while (!bus_if.biu_cp0_lpmd_ack && n < 20) begin cycle(); n++; end
    chk("busy_ack_lat", n, QUIET_DLY);
    idle(0); cycle();

    // Request dropped mid-QUIET never acks.
    idle(1); cycle();
    drv(1,0,0, 0,0,0, 0,0,0,0, 0,0, 1); cycle();
    idle(0); cycle();
    repeat (3) cycle();
    chk("no_ack", bus_if.biu_cp0_lpmd_ack, 0);

    // Asynchronous reset while acked.
    idle(1); repeat (QUIET_DLY + 1) cycle();
    chk("pre_rst_ack", bus_if.biu_cp0_lpmd_ack, 1);
    #2 rst_b = 1'b0;
    #1;
    chk("arst_ack", bus_if.biu_cp0_lpmd_ack, 0);
    chk("arst_blk", bus_if.biu_lpmd_block, 0);
    model_reset();
    idle(0);
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic with shifting bias.
    mode = 0;
    for (int i = 0; i < 3000; i++) begin
      bit lp;
      int inc_p, dec_p;
      if (i % 200 == 0) mode = $urandom_range(0, 2);
      inc_p = (mode == 1) ? 80 : (mode == 2) ? 15 : 45;
      dec_p = (mode == 2) ? 80 : (mode == 1) ? 15 : 45;
      lp = bus_if.cp0_biu_lpmd_req;
      if ($urandom_range(0, 39) == 0) lp = ~lp;
      drv($urandom_range(0, 9) == 0,
          $urandom_range(0, 99) < inc_p, $urandom_range(0, 3) != 0,
          $urandom_range(0, 99) < dec_p, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 9) == 0,
          $urandom_range(0, 99) < inc_p, $urandom_range(0, 3) != 0,
          $urandom_range(0, 9) == 0,
          $urandom_range(0, 99) < dec_p, $urandom_range(0, 3) != 0,
          lp);
      if (mode == 0 && $urandom_range(0, 2) == 0) idle(lp);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/ct_biu_outstd_tracker.md
# ct_biu_outstd_tracker

Tracks outstanding AXI read and write transactions at the BIU pad boundary. From these counts it generates the channel busy indications and clock-gating enables consumed by the BIU low-power gated-clock block. It also runs the low-power-mode request/acknowledge handshake with CP0: new issue is blocked, the bus is confirmed quiet for a programmable number of cycles, then the request is acknowledged. It runs on the ungated clock so it can observe traffic while the channel clocks are off.

## Interface
Parameters:
- RD_MAX, 16 — maximum outstanding reads.
- WR_MAX, 16 — maximum outstanding writes.
- CNT_W, 5 — counter width. Must satisfy 2^CNT_W > max(RD_MAX, WR_MAX).
- QUIET_DLY, 2 — consecutive idle cycles required before ack. Legal range is 1..15.

Ports:
- forever_coreclk  in  1  free-running core clock; all flops rise on it.
- cpurst_b  in  1  asynchronous active-low reset.
- rd_req_vld  in  1  internal read request pending toward AR.
- biu_pad_arvalid / pad_biu_arready  in  1 each  AR handshake.
- pad_biu_rvalid / biu_pad_rready / pad_biu_rlast  in  1 each  R handshake.
- wr_req_vld  in  1  internal write request pending toward AW.
- biu_pad_awvalid / pad_biu_awready  in  1 each  AW handshake.
- biu_pad_wvalid  in  1  write data pending.
- pad_biu_bvalid / biu_pad_bready  in  1 each  B handshake.
- cp0_biu_lpmd_req  in  1  low-power-mode request; level.
- read_busy  out  1  reads in flight or pending.
- write_busy  out  1  writes in flight or pending.
- read_ar_clk_en, read_r_clk_en, write_b_clk_en  out  1 each  clock enables for the gated cells.
- biu_lpmd_block  out  1  stall new AR/AW issue.
- biu_cp0_lpmd_ack  out  1  low-power acknowledge.
- rd_cnt_full, wr_cnt_full  out  1 each  count equals the max; upstream must not issue.
- biu_outstd_err  out  2  sticky error flags: [0] read, [1] write.

## Operation
- Read increment (rd_inc) is arvalid&arready. Read decrement (rd_dec) is rvalid&rready&rlast.
- Write increment (wr_inc) is awvalid&awready. Write decrement (wr_dec) is bvalid&bready.
- Counter update rules:
  - increment only: +1;
  - decrement only: −1;
  - both in the same cycle: unchanged;
  - increment at MAX: hold, flag overflow;
  - decrement at 0: hold, flag underflow.
- read_busy = rd_cnt!=0 | rd_req_vld | biu_pad_arvalid.
- write_busy = wr_cnt!=0 | wr_req_vld | biu_pad_awvalid | biu_pad_wvalid.
- read_ar_clk_en = rd_req_vld | biu_pad_arvalid.
- read_r_clk_en = rd_cnt!=0 | pad_biu_rvalid.
- write_b_clk_en = wr_cnt!=0 | pad_biu_bvalid.
- Full flags: rd_cnt_full = (rd_cnt==RD_MAX); wr_cnt_full = (wr_cnt==WR_MAX).
- Low-power FSM has three states: IDLE, QUIET, ACK.
  - IDLE: on lpmd_req go to QUIET and clear quiet_cnt.
  - QUIET:
    - If req drops, go to IDLE.
    - Else if read_busy|write_busy, clear quiet_cnt.
    - Else increment quiet_cnt; when it reaches QUIET_DLY, go to ACK.
  - ACK: when req drops, go to IDLE. Busy seen in ACK (the bus is misbehaving) does not drop ack.
- biu_lpmd_block = (state!=IDLE). biu_cp0_lpmd_ack = (state==ACK). Both are registered state decodes.

## Timing
- Reset values: rd_cnt=0, wr_cnt=0, state=IDLE, quiet_cnt=0, err=0. All outputs are 0 except those driven combinationally by inputs.
- Counters update on the edge after the handshake. busy and clk_en reflect the counter one cycle after the handshake, but reflect request/valid inputs in the same cycle.
- Minimum request-to-ack latency, bus idle: 1 cycle into QUIET plus QUIET_DLY cycles. With QUIET_DLY=2, ack rises 3 edges after req is sampled.
- Ack falls on the edge after req is sampled low. biu_lpmd_block falls on the same edge.
- Upstream may still complete a handshake that was already accepted while block is asserted. Such a handshake counts and restarts quiet.
- Reset mid-operation clears everything asynchronously, with no ack glitch.

## Configuration
- CT_BIU_OUTSTD_ERR_EN defined:
  - overflow/underflow set the corresponding biu_outstd_err bit;
  - the bits are sticky until reset.
- CT_BIU_OUTSTD_ERR_EN undefined:
  - biu_outstd_err is tied to 2'b00 and the error logic is not synthesised;
  - counter hold behaviour is unchanged.

## Test plan
- Issue 3 AR handshakes, then return 3 R beats with rlast → rd_cnt goes 1,2,3,2,1,0; read_busy stays 1 until the cycle after the last decrement.
- Same-cycle AR accept and R last, with rd_cnt=4 → rd_cnt stays 4 and no error.
- 16 AW with no B → wr_cnt_full=1. A 17th AW handshake → wr_cnt holds at 16 and biu_outstd_err[1]=1 (macro on) or 0 (macro off).
- B handshake at wr_cnt=0 → wr_cnt stays 0; err[1]=1 (macro on).
- lpmd_req with bus idle and QUIET_DLY=2 → block=1 after 1 edge, ack=1 after 3 edges. Drop req → ack=0 and block=0 after 1 edge.
- lpmd_req while rd_cnt=2 → ack stays 0 until both R last beats complete and 2 further idle cycles elapse. Drop req mid-QUIET → back to IDLE, ack never asserts.
